pipe_skid_register: RTL and testbench

Parametrised pipeline stage register for the pipelined LC-3b datapath. It adds a valid/ready handshake, a one-entry skid buffer and synchronous flush to the plain load/flush stage latch. Each inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can then stall locally without a combinational ready path through the stage. Flush squashes in-flight instructions on branch redirect.

---
 rtl/pipe_skid_register_if.sv | 24 ++
 rtl/pipe_skid_register.sv | 98 +++++++++
 tb/tb_pipe_skid_register.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_register_if.sv
// Handshake bundle for one pipeline stage boundary: upstream offer, downstream
// accept, squash, and the stage's fill level.
interface pipe_skid_register_if #(
    parameter int unsigned WIDTH = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_register.sv
// Pipeline stage latch with valid/ready handshake, one-entry skid buffer and
// synchronous flush; all outputs are decoded from registered state only.
module pipe_skid_register #(
    parameter int unsigned WIDTH          = 16,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pipe_skid_register_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;
    logic             w_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_main <= '0;
                r_skid <= '0;
            end else begin
                if (w_main_load)
                    r_main <= bus.in_data;
                else if (w_main_from_skid)
                    r_main <= r_skid;
                if (w_skid_load)
                    r_skid <= bus.in_data;
            end
        end
    end

    // flush overrides every handshake; in SKID in_valid is ignored since in_ready is low
    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_clear          = 1'b0;
        if (bus.flush) begin
            w_state_next = S_EMPTY;
            w_clear      = CLEAR_ON_FLUSH;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (bus.in_valid) begin
                        w_main_load  = 1'b1;
                        w_state_next = S_FULL;
                    end
                end
                S_FULL: begin
                    if (bus.out_ready && bus.in_valid) begin
                        w_main_load = 1'b1;
                    end else if (bus.out_ready) begin
                        w_state_next = S_EMPTY;
                    end else if (bus.in_valid) begin
                        w_skid_load  = 1'b1;
                        w_state_next = S_SKID;
                    end
                end
                S_SKID: begin
                    if (bus.out_ready) begin
                        w_main_from_skid = 1'b1;
                        w_state_next     = S_FULL;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.occupancy = 2'd0;
        case (r_state)
            S_FULL:  bus.occupancy = 2'd1;
            S_SKID:  bus.occupancy = 2'd2;
            default: bus.occupancy = 2'd0;
        endcase
    end

    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.in_ready  = (r_state != S_SKID);
    assign bus.out_data  = r_main;
endmodule

// File: tb/tb_pipe_skid_register.sv
// Self-checking bench: two stages (clear-on-flush and keep-on-flush) share one
// stimulus stream and are compared against a queue-based FIFO model.
module tb_pipe_skid_register;
    logic        clk;
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        fl;

    int unsigned checks;
    int unsigned errors;

    logic [15:0] q[$];
    logic [15:0] mc;
    logic [15:0] mk;

    pipe_skid_register_if #(.WIDTH(16)) bc ();
    pipe_skid_register_if #(.WIDTH(16)) bk ();

    assign bc.in_valid  = iv;
    assign bc.in_data   = id;
    assign bc.out_ready = ordy;
    assign bc.flush     = fl;
    assign bk.in_valid  = iv;
    assign bk.in_data   = id;
    assign bk.out_ready = ordy;
    assign bk.flush     = fl;

    pipe_skid_register #(.WIDTH(16), .CLEAR_ON_FLUSH(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(bc)
    );
    pipe_skid_register #(.WIDTH(16), .CLEAR_ON_FLUSH(1'b0)) dut_k (
        .clk(clk), .rst(rst), .bus(bk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] exp_vec(input logic [15:0] d);
        logic [1:0] n;
        n = 2'(q.size());
        return {q.size() != 0, q.size() != 2, n, d};
    endfunction

    function automatic logic [19:0] got_c();
        return {bc.out_valid, bc.in_ready, bc.occupancy, bc.out_data};
    endfunction

    function automatic logic [19:0] got_k();
        return {bk.out_valid, bk.in_ready, bk.occupancy, bk.out_data};
    endfunction

    // Drive one cycle of inputs, advance the reference, then land just after the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic r, input logic f);
        bit pop;
        bit push;
        iv = v; id = d; ordy = r; fl = f;
        if (f) begin
            q.delete();
            mc = '0;
        end else begin
            pop  = (q.size() > 0) && r;
            push = v && (q.size() < 2);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
            if (q.size() > 0) begin
                mc = q[0];
                mk = q[0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; id = '0; ordy = 1'b0; fl = 1'b0;
        q.delete(); mc = '0; mk = '0;
        #2;
        checks++;
        if (got_c() !== 20'h4_0000) begin
            errors++; $display("FAIL reset_during_c: got %h want %h", got_c(), 20'h4_0000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (got_c() !== exp_vec(mc)) begin
            errors++; $display("FAIL reset_after_c: got %h want %h", got_c(), exp_vec(mc));
        end
        checks++;
        if (got_k() !== exp_vec(mk)) begin
            errors++; $display("FAIL reset_after_k: got %h want %h", got_k(), exp_vec(mk));
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 16'(i), 1'b1, 1'b0);
            checks++;
            if (bc.out_data !== 16'(i) || bc.occupancy !== 2'd1 || bc.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got data %h occ %0d valid %b want data %h occ 1 valid 1",
                         i, bc.out_data, bc.occupancy, bc.out_valid, 16'(i));
            end
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (got_k() !== exp_vec(mk) || got_k() !== 20'h4_0005) begin
            errors++; $display("FAIL stream_drain_k: got %h want %h", got_k(), 20'h4_0005);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        checks++;
        if (got_c() !== 20'hD_AAAA) begin
            errors++; $display("FAIL bp_first: got %h want %h", got_c(), 20'hD_AAAA);
        end
        step(1'b1, 16'hBBBB, 1'b0, 1'b0);
        checks++;
        if (got_c() !== 20'hA_AAAA) begin
            errors++; $display("FAIL bp_skid: got %h want %h", got_c(), 20'hA_AAAA);
        end
        step(1'b1, 16'hCCCC, 1'b0, 1'b0);
        checks++;
        if (got_k() !== 20'hA_AAAA || got_k() !== exp_vec(mk)) begin
            errors++; $display("FAIL bp_hold: got %h want %h", got_k(), 20'hA_AAAA);
        end
    endtask

    task automatic test_drain();
        step(1'b1, 16'hCCCC, 1'b1, 1'b0);
        checks++;
        if (got_c() !== 20'hD_BBBB) begin
            errors++; $display("FAIL drain_1: got %h want %h", got_c(), 20'hD_BBBB);
        end
        step(1'b1, 16'hCCCC, 1'b1, 1'b0);
        checks++;
        if (got_c() !== 20'hD_CCCC) begin
            errors++; $display("FAIL drain_2: got %h want %h", got_c(), 20'hD_CCCC);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (got_c() !== 20'h4_CCCC || got_c() !== exp_vec(mc)) begin
            errors++; $display("FAIL drain_3: got %h want %h", got_c(), 20'h4_CCCC);
        end
    endtask

    task automatic test_flush_clear();
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b1);
        checks++;
        if (got_c() !== 20'h4_0000) begin
            errors++; $display("FAIL flush_clear_c: got %h want %h", got_c(), 20'h4_0000);
        end
        checks++;
        if (got_k() !== 20'h4_1111) begin
            errors++; $display("FAIL flush_clear_k: got %h want %h", got_k(), 20'h4_1111);
        end
    endtask

    task automatic test_flush_keep();
        step(1'b1, 16'h5A5A, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (got_k() !== 20'h4_5A5A) begin
            errors++; $display("FAIL flush_keep_k: got %h want %h", got_k(), 20'h4_5A5A);
        end
        checks++;
        if (got_c() !== 20'h4_0000) begin
            errors++; $display("FAIL flush_keep_c: got %h want %h", got_c(), 20'h4_0000);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 16'h0007, 1'b0, 1'b0);
        step(1'b1, 16'h0008, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        q.delete(); mc = '0; mk = '0;
        checks++;
        if (got_c() !== 20'h4_0000) begin
            errors++; $display("FAIL async_rst_c: got %h want %h", got_c(), 20'h4_0000);
        end
        checks++;
        if (got_k() !== 20'h4_0000) begin
            errors++; $display("FAIL async_rst_k: got %h want %h", got_k(), 20'h4_0000);
        end
        iv = 1'b0; ordy = 1'b0; fl = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            checks++;
            if (got_c() !== exp_vec(mc)) begin
                errors++; $display("FAIL random_c[%0d]: got %h want %h", n, got_c(), exp_vec(mc));
            end
            checks++;
            if (got_k() !== exp_vec(mk)) begin
                errors++; $display("FAIL random_k[%0d]: got %h want %h", n, got_k(), exp_vec(mk));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_flush_clear();
        test_flush_keep();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
